rv_branch_predict: RTL and testbench
====================================

# rv_branch_predict

Fetch-stage branch predictor and resolution unit for the 64-bit RV core. It supplies a taken/target prediction for the current fetch PC from a direct-mapped table of 2-bit saturating counters and branch targets. It consumes the resolved `taken` outcome from the execute-stage branch test together with the prediction carried down the pipeline. It trains the tables and raises a registered one-cycle redirect whenever the prediction was wrong.

## Interface
- `ENTRIES`, 64: number of table entries; must be a power of two, 4 or more. `IDX_W = log2(ENTRIES)`.
- `TAG_W`, `62-IDX_W`: tag width; the tag is `pc[IDX_W+2 +: TAG_W]`.

All ports: one clock; reset is synchronous and active-high.

- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `pc_i` input 64: fetch PC to predict.
- `pred_taken_o` output 1: predicted taken (combinational).
- `pred_target_o` output 64: predicted next PC (combinational).
- `upd_valid_i` input 1: a resolved conditional branch is presented this cycle.
- `upd_pc_i` input 64: PC of the resolved branch.
- `upd_taken_i` input 1: actual outcome from the execute-stage branch test.
- `upd_target_i` input 64: computed branch target.
- `upd_pred_target_i` input 64: `pred_target_o` captured when this branch was fetched.
- `mispredict_o` output 1: registered one-cycle pulse indicating the pipeline must flush.
- `redirect_pc_o` output 64: correct next PC; valid while `mispredict_o` is high.
- `stat_branches_o` output 32: resolved-branch count (see Configuration).
- `stat_mispred_o` output 32: misprediction count (see Configuration).

## Operation
- Each entry holds `valid`, `tag[TAG_W]`, `target[64]` and `ctr[2]`.
- Index is `pc[IDX_W+1:2]`. Bits `pc[1:0]` are ignored.
- **Lookup** (combinational):
  - `hit = valid[idx] & (tag[idx] == pc_i tag)`.
  - `pred_taken_o = hit & ctr[idx][1]`.
  - `pred_target_o = pred_taken_o ? target[idx] : pc_i + 4`. The addition is 64-bit and wraps modulo 2^64.
- **Update**, applied on the edge when `upd_valid_i` is high, looked up at `upd_pc_i`:
  - Tag hit, taken: `ctr` increments, saturating at 2'b11. `target` is rewritten with `upd_target_i`.
  - Tag hit, not taken: `ctr` decrements, saturating at 2'b00. `target` is unchanged.
  - Tag miss, taken: allocate the entry. Set `valid=1`, write tag and target, set `ctr=2'b10` (weakly taken). Any previous occupant is overwritten.
  - Tag miss, not taken: no table change.
- **Resolution**, computed from the update inputs:
  - `actual_next = upd_taken_i ? upd_target_i : upd_pc_i + 4`.
  - A misprediction occurs when `upd_valid_i` is high and `actual_next != upd_pred_target_i`.
- **Output registers**:
  - `mispredict_o` is registered from the misprediction condition.
  - `redirect_pc_o` is registered from `actual_next`. It updates only when a misprediction is registered and otherwise holds its last value.
- **Same-cycle lookup and update to one index**: the lookup returns the pre-update contents. There is no bypass.
- No state machine; the only sequential elements are the table, the output registers and the statistics counters.

## Timing
- Lookup has zero-cycle latency: `pred_*` follow `pc_i` in the same cycle.
- A table write becomes visible to a lookup on the cycle after the `upd_valid_i` edge.
- `mispredict_o` asserts exactly one cycle after the `upd_valid_i` cycle and stays high for exactly one cycle per mispredicted update.
- Back-to-back mispredicted updates produce back-to-back pulses, each carrying its own `redirect_pc_o`.
- **Reset values** (reset takes priority over an update in the same cycle, which is discarded):
  - All `valid` = 0 and all `ctr` = 2'b01.
  - `tag` and `target` are don't-care.
  - `mispredict_o` = 0 and `redirect_pc_o` = 0.
  - Statistics counters = 0.
- **Reset asserted while a misprediction pulse is pending**: the pulse is suppressed.

## Configuration
- `BP_STATS_EN` defined:
  - `stat_branches_o` increments on every `upd_valid_i` cycle.
  - `stat_mispred_o` increments on every mispredicted update.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- `BP_STATS_EN` undefined: no counters are synthesized, and both ports are tied to 0.

## Test plan
- **Cold miss**: reset, then present `pc_i=0x1000`. Required: `pred_taken_o=0`, `pred_target_o=0x1004`.
- **Allocation and training**:
  - Update `pc=0x1000`, taken, target `0x2000`, pred target `0x1004`. Required next cycle: `mispredict_o=1`, `redirect_pc_o=0x2000`, and a lookup of 0x1000 gives taken with target 0x2000.
  - Repeat the update two more times. Required: `ctr` saturates at 11, with no further mispredicts once the correct prediction is passed in.
- **Hysteresis**: from `ctr=11`, present one not-taken update. Required: the prediction is still taken. After a second not-taken update, the prediction is not taken and the target is 0x1004.
- **Aliasing**: with ENTRIES=64, a taken update at `0x1000 + 64*4` evicts 0x1000. Required: a lookup of 0x1000 misses.
- **Simultaneous events**:
  - Update and lookup to the same index in one cycle. Required: the lookup shows the old value.
  - Reset asserted together with a mispredicted update. Required: no pulse, and the table stays cleared.
- **Statistics** (`BP_STATS_EN` defined): 5 updates, 2 of them mispredicted. Required: `stat_branches_o=5`, `stat_mispred_o=2`. Preloading the counters to 0xFFFFFFFF and applying one update wraps them to 0.

Source files
------------

// File: rtl/rv_branch_predict.sv
// Fetch-stage branch predictor: direct-mapped 2-bit counter + target table with registered mispredict redirect.
// Optional build macro BP_STATS_EN adds resolved-branch and misprediction counters.
module rv_branch_predict #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 62 - IDX_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] pc_i,
  output logic        pred_taken_o,
  output logic [63:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [63:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [63:0] upd_target_i,
  input  logic [63:0] upd_pred_target_i,
  output logic        mispredict_o,
  output logic [63:0] redirect_pc_o,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispred_o
);

  logic             valid_q [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [63:0]      tgt_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic [1:0]       ctr_d;
  logic             ctr_we, tgt_we;
  logic [63:0]      actual_next;
  logic             mis_d;
  logic             mis_q;
  logic [63:0]      redir_q;
  logic             unused_pc_lsb;

  assign unused_pc_lsb = ^{pc_i[1:0], upd_pc_i[1:0]};

  // Lookup stage: reads pre-update table contents (no bypass)
  assign lk_idx        = pc_i[IDX_W+1:2];
  assign lk_tag        = pc_i[IDX_W+2 +: TAG_W];
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = lk_hit & ctr_q[lk_idx][1];
  assign pred_target_o = pred_taken_o ? tgt_q[lk_idx] : pc_i + 64'd4;

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[IDX_W+2 +: TAG_W];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    ctr_d = ctr_q[up_idx];
    if (up_hit) begin
      if (upd_taken_i) begin
        if (ctr_q[up_idx] != 2'b11) ctr_d = ctr_q[up_idx] + 2'b01;
      end else begin
        if (ctr_q[up_idx] != 2'b00) ctr_d = ctr_q[up_idx] - 2'b01;
      end
    end else begin
      ctr_d = 2'b10;
    end
  end

  // A miss that resolves not-taken leaves the table untouched
  assign ctr_we = upd_valid_i & (up_hit | upd_taken_i);
  assign tgt_we = upd_valid_i & upd_taken_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (ctr_we) begin
      valid_q[up_idx] <= 1'b1;
      ctr_q[up_idx]   <= ctr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tgt_we) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target_i;
    end
  end

  // Resolution stage: registered one-cycle redirect
  assign actual_next = upd_taken_i ? upd_target_i : upd_pc_i + 64'd4;
  assign mis_d       = upd_valid_i && (actual_next != upd_pred_target_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mis_q   <= 1'b0;
      redir_q <= 64'd0;
    end else begin
      mis_q <= mis_d;
      if (mis_d) redir_q <= actual_next;
    end
  end

  assign mispredict_o  = mis_q;
  assign redirect_pc_o = redir_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      if (upd_valid_i) stat_br_q <= stat_br_q + 32'd1;
      if (mis_d)       stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches_o = stat_br_q;
  assign stat_mispred_o  = stat_mp_q;
`else
  assign stat_branches_o = 32'd0;
  assign stat_mispred_o  = 32'd0;
`endif

endmodule

// File: tb/tb_rv_branch_predict.sv
// Scoreboard bench for rv_branch_predict (ENTRIES=64): reference table model plus directed and random updates.
module tb_rv_branch_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic [63:0] upd_pred_target;
  logic        mispredict;
  logic [63:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  always #5 clk = ~clk;

  rv_branch_predict #(.ENTRIES(64)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc),
    .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_target_i(upd_pred_target),
    .mispredict_o(mispredict), .redirect_pc_o(redirect_pc),
    .stat_branches_o(stat_branches), .stat_mispred_o(stat_mispred)
  );

  typedef struct {
    logic        mis;
    logic [63:0] redir;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;
  exp_t sb_q[$];

  // Reference model of the table
  logic        m_valid [64];
  logic [55:0] m_tag   [64];
  logic [63:0] m_tgt   [64];
  logic [1:0]  m_ctr   [64];
  logic [63:0] m_redir;
  logic [31:0] m_br, m_mp;
  logic        m_init = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void mlook(input logic [63:0] a, output logic t, output logic [63:0] tg);
    logic [5:0] i;
    i = a[7:2];
    t = m_valid[i] && (m_tag[i] == a[63:8]) && m_ctr[i][1];
    tg = t ? m_tgt[i] : a + 64'd4;
  endfunction

  task automatic look(input logic [63:0] a, input logic et, input logic [63:0] etg);
    pc = a;
    #1;
    check("look_taken", {63'd0, pred_taken}, {63'd0, et});
    check("look_target", pred_target, etg);
  endtask

  // One clock: drive, check lookup against model pre-edge, push expectation, edge, pop and compare
  task automatic cyc(input logic r, input logic v, input logic [63:0] lpc, input logic [63:0] upc,
                     input logic tk, input logic [63:0] tgt, input logic [63:0] ptgt);
    logic        et, hit, mis;
    logic [63:0] etg, act;
    logic [5:0]  i;
    exp_t        e, g;
    rst = r; upd_valid = v; pc = lpc; upd_pc = upc; upd_taken = tk;
    upd_target = tgt; upd_pred_target = ptgt;
    #1;
    if (m_init) begin
      mlook(lpc, et, etg);
      check("pred_taken", {63'd0, pred_taken}, {63'd0, et});
      check("pred_target", pred_target, etg);
    end
    act = tk ? tgt : upc + 64'd4;
    mis = v && (act != ptgt);
    i = upc[7:2];
    hit = m_valid[i] && (m_tag[i] == upc[63:8]);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 64; k++) begin m_valid[k] = 1'b0; m_ctr[k] = 2'b01; end
      m_redir = 64'd0; m_br = 32'd0; m_mp = 32'd0; mis = 1'b0; m_init = 1'b1;
    end else begin
      if (v && hit) begin
        if (tk) begin
          m_ctr[i] = (m_ctr[i] == 2'b11) ? 2'b11 : m_ctr[i] + 2'b01;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 2'b00) ? 2'b00 : m_ctr[i] - 2'b01;
        end
      end else if (v && tk) begin
        m_valid[i] = 1'b1; m_tag[i] = upc[63:8]; m_tgt[i] = tgt; m_ctr[i] = 2'b10;
      end
      if (mis) m_redir = act;
      if (v) m_br = m_br + 32'd1;
      if (mis) m_mp = m_mp + 32'd1;
    end
`ifdef BP_STATS_EN
    e.br = m_br; e.mp = m_mp;
`else
    e.br = 32'd0; e.mp = 32'd0;
`endif
    e.mis = mis; e.redir = m_redir;
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      g = sb_q.pop_front();
      check("mispredict", {63'd0, mispredict}, {63'd0, g.mis});
      if (m_init) begin
        check("redirect_pc", redirect_pc, g.redir);
        check("stat_branches", {32'd0, stat_branches}, {32'd0, g.br});
        check("stat_mispred", {32'd0, stat_mispred}, {32'd0, g.mp});
      end
    end
  endtask

  initial begin
    logic        t;
    logic [63:0] tg, a;
    rst = 1'b1; upd_valid = 1'b0; pc = 64'd0; upd_pc = 64'd0; upd_taken = 1'b0;
    upd_target = 64'd0; upd_pred_target = 64'd0;
    for (int k = 0; k < 64; k++) begin m_valid[k] = 1'b0; m_ctr[k] = 2'b01; m_tag[k] = '0; m_tgt[k] = '0; end
    m_redir = 64'd0; m_br = 32'd0; m_mp = 32'd0;

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_mispredict", {63'd0, mispredict}, 64'd0);
    check("rst_redirect", redirect_pc, 64'd0);

    // Cold miss
    look(64'h1000, 1'b0, 64'h1004);

    // Allocation, then training to saturation
    cyc(0, 1, 64'h1000, 64'h1000, 1, 64'h2000, 64'h1004);
    check("alloc_mispredict", {63'd0, mispredict}, 64'd1);
    check("alloc_redirect", redirect_pc, 64'h2000);
    look(64'h1000, 1'b1, 64'h2000);
    cyc(0, 1, 64'h1000, 64'h1000, 1, 64'h2000, 64'h2000);
    cyc(0, 1, 64'h1000, 64'h1000, 1, 64'h2000, 64'h2000);
    check("train_no_mis", {63'd0, mispredict}, 64'd0);
    check("train_ctr_model", {62'd0, m_ctr[0]}, 64'd3);

    // Hysteresis: two back-to-back not-taken mispredicts
    cyc(0, 1, 64'h1000, 64'h1000, 0, 64'h2000, 64'h2000);
    check("nt1_redirect", redirect_pc, 64'h1004);
    look(64'h1000, 1'b1, 64'h2000);
    cyc(0, 1, 64'h1000, 64'h1000, 0, 64'h2000, 64'h2000);
    check("nt2_mispredict", {63'd0, mispredict}, 64'd1);
    look(64'h1000, 1'b0, 64'h1004);

    // Aliasing: 0x1100 shares index 0 and evicts 0x1000
    cyc(0, 1, 64'h1000, 64'h1000, 1, 64'h2000, 64'h1004);
    look(64'h1000, 1'b1, 64'h2000);
    cyc(0, 1, 64'h1100, 64'h1100, 1, 64'h3000, 64'h1104);
    look(64'h1000, 1'b0, 64'h1004);
    look(64'h1100, 1'b1, 64'h3000);

    // Same-cycle update and lookup: old value seen, new one next cycle
    upd_valid = 1'b1; upd_pc = 64'h1100; upd_taken = 1'b1; upd_target = 64'h4000;
    upd_pred_target = 64'h3000;
    look(64'h1100, 1'b1, 64'h3000);
    cyc(0, 1, 64'h1100, 64'h1100, 1, 64'h4000, 64'h3000);
    look(64'h1100, 1'b1, 64'h4000);

    // Reset together with a mispredicted update
    cyc(1, 1, 64'h1200, 64'h1200, 1, 64'h5000, 64'h1204);
    check("rst_upd_no_pulse", {63'd0, mispredict}, 64'd0);
    check("rst_upd_redirect", redirect_pc, 64'd0);
    look(64'h1200, 1'b0, 64'h1204);
    look(64'h1100, 1'b0, 64'h1104);

    // Random updates over a small aliasing PC set; pred target mostly from model
    for (int n = 0; n < 60; n++) begin
      a = {48'd0, 4'h1, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'b00} << 0;
      a = 64'h1000 + (64'($urandom_range(0, 3)) << 8) + (64'($urandom_range(0, 3)) << 2);
      mlook(a, t, tg);
      if ($urandom_range(0, 3) == 0) tg = 64'($urandom);
      cyc(0, $urandom_range(0, 4) != 0, a, a, 1'($urandom_range(0, 1)),
          64'h8000 + 64'($urandom_range(0, 15) << 2), tg);
    end

`ifdef BP_STATS_EN
    // Counter wrap from all-ones
    dut.stat_br_q = 32'hFFFF_FFFF;
    dut.stat_mp_q = 32'hFFFF_FFFF;
    m_br = 32'hFFFF_FFFF; m_mp = 32'hFFFF_FFFF;
    cyc(0, 1, 64'h1300, 64'h1300, 1, 64'h9000, 64'h1304);
    check("wrap_branches", {32'd0, stat_branches}, 64'd0);
    check("wrap_mispred", {32'd0, stat_mispred}, 64'd0);
`else
    check("stats_tied_br", {32'd0, stat_branches}, 64'd0);
    check("stats_tied_mp", {32'd0, stat_mispred}, 64'd0);
`endif

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
